// File: rtl/microwave_entry_controller_pkg.sv
// Shared types and defaults for the microwave keypad/timer sequencer.
package microwave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [15:0] BCD_ZERO_TIME       = 16'h0000;
  localparam int          DEF_TICKS_PER_SEC   = 50_000_000;
  localparam int          DEF_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/microwave_entry_controller_key_debouncer.sv
// Turns the priority encoder's level output into one strobe per debounced key press.
module key_debouncer
  import microwave_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  bcd_digit_t key_bcd,
  input  logic       key_valid,
  output logic       digit_strobe,
  output bcd_digit_t digit
);

  localparam int             CW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  LIMIT = CW'(DEBOUNCE_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d, run;
  logic          armed_q, armed_d;
  logic          hit;
  bcd_digit_t    last_q;

  // While armed, cnt counts stable pressed cycles; while disarmed, released cycles.
  always_comb begin
    cnt_d   = '0;
    armed_d = armed_q;
    hit     = 1'b0;
    run     = cnt_q + 1'b1;
    if (armed_q) begin
      if (key_valid) begin
        if ((cnt_q != '0) && (key_bcd != last_q)) run = CW'(1);
        if (run == LIMIT) begin
          hit     = 1'b1;
          armed_d = 1'b0;
        end else begin
          cnt_d = run;
        end
      end
    end else if (!key_valid) begin
      if (run == LIMIT) armed_d = 1'b1;
      else              cnt_d   = run;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      armed_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
    last_q <= key_bcd;
  end

  // Codes above 9 still consume the press but never reach the time register.
  assign digit_strobe = hit && (key_bcd <= 4'd9);
  assign digit        = key_bcd;

endmodule

// File: rtl/microwave_entry_controller.sv
// Keypad entry, start/pause/clear sequencing and MM:SS countdown for the microwave.
module microwave_entry_controller
  import microwave_pkg::*;
#(
  parameter int TICKS_PER_SEC   = DEF_TICKS_PER_SEC,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_bcd,
  input  logic        key_valid,
  input  logic        start,
  input  logic        stop_clear,
  input  logic        door_closed,
  output logic        enc_enablen,
  output logic [15:0] time_bcd,
  output logic        magnetron_on,
  output logic        done,
  output logic [2:0]  state
);

  localparam int            TW        = $clog2(TICKS_PER_SEC);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);

  state_t        state_q, state_d;
  logic [15:0]   time_q, time_d, shifted, dec;
  logic [TW-1:0] tick_q, tick_d;
  logic          mag_q, start_q, stop_q;
  logic          start_edge, stop_edge, start_ok, tick;
  logic          digit_strobe;
  bcd_digit_t    digit;

  // MM:SS decrement; seconds tens borrow from 0 to 5, entered values above 59 pass through.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    bcd_digit_t mt, mu, st, su;
    {mt, mu, st, su} = t;
    if (su != 4'd0) su = su - 4'd1;
    else begin
      su = 4'd9;
      if (st != 4'd0) st = st - 4'd1;
      else begin
        st = 4'd5;
        if (mu != 4'd0) mu = mu - 4'd1;
        else begin
          mu = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mu, st, su};
  endfunction

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debouncer (
    .clk         (clk),
    .rst         (rst),
    .key_bcd     (key_bcd),
    .key_valid   (key_valid),
    .digit_strobe(digit_strobe),
    .digit       (digit)
  );

  assign start_edge = start & ~start_q;
  assign stop_edge  = stop_clear & ~stop_q;

  always_comb begin
    state_d  = state_q;
    time_d   = time_q;
    shifted  = {time_q[11:0], digit};
    dec      = bcd_dec(time_q);
    tick     = (state_q == ST_COOK) && (tick_q == TICK_LAST);
    start_ok = start_edge && door_closed && (time_q != BCD_ZERO_TIME);
    unique case (state_q)
      ST_IDLE, ST_SET: begin
        if (stop_edge) begin
          state_d = ST_IDLE;
          time_d  = BCD_ZERO_TIME;
        end else if (start_ok) begin
          state_d = ST_COOK;
        end else if (digit_strobe) begin
          time_d  = shifted;
          state_d = (shifted != BCD_ZERO_TIME) ? ST_SET : ST_IDLE;
        end
      end
      ST_COOK: begin
        if (stop_edge || !door_closed) begin
          state_d = ST_PAUSE;
        end else if (tick) begin
          time_d = dec;
          if (dec == BCD_ZERO_TIME) state_d = ST_DONE;
        end
      end
      ST_PAUSE: begin
        if (stop_edge) begin
          state_d = ST_IDLE;
          time_d  = BCD_ZERO_TIME;
        end else if (start_ok) begin
          state_d = ST_COOK;
        end
      end
      ST_DONE: begin
        if (stop_edge || start_edge) begin
          state_d = ST_IDLE;
          time_d  = BCD_ZERO_TIME;
        end
      end
      default: begin
        state_d = ST_IDLE;
        time_d  = BCD_ZERO_TIME;
      end
    endcase
    // A partial second is discarded whenever COOK is entered or left.
    if ((state_q == ST_COOK) && (state_d == ST_COOK)) tick_d = tick ? '0 : tick_q + 1'b1;
    else                                              tick_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      time_q  <= BCD_ZERO_TIME;
      tick_q  <= '0;
      mag_q   <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      tick_q  <= tick_d;
      mag_q   <= (state_d == ST_COOK);
      start_q <= start;
      stop_q  <= stop_clear;
    end
  end

  // Door gating is combinational so opening the door cuts heating immediately.
  assign magnetron_on = mag_q & door_closed;
  assign enc_enablen  = !((state_q == ST_IDLE) || (state_q == ST_SET));
  assign done         = (state_q == ST_DONE);
  assign time_bcd     = time_q;
  assign state        = state_q;

endmodule

// File: tb/tb_microwave_entry_controller.sv
// Vector-table and scoreboard bench for microwave_entry_controller (DEBOUNCE=4, TICKS=10).
module tb_microwave_entry_controller;

  localparam logic [2:0] S_IDLE = 3'd0, S_SET = 3'd1, S_COOK = 3'd2, S_PAUSE = 3'd3, S_DONE = 3'd4;

  logic        clk = 1'b0;
  logic        rst, key_valid, start, stop_clear, door_closed;
  logic [3:0]  key_bcd;
  logic        enc_enablen, magnetron_on, done;
  logic [15:0] time_bcd;
  logic [2:0]  state;

  typedef struct {
    bit          r;
    logic [3:0]  kb;
    bit          kv, st, sc, dc;
    int          n;
    logic [15:0] t;
    logic [2:0]  s;
    bit          m;
  } vec_t;

  typedef struct packed {
    logic [15:0] t;
    logic [2:0]  s;
    logic        m;
    logic        d;
    logic        e;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  microwave_entry_controller #(
    .TICKS_PER_SEC  (10),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_bcd     (key_bcd),
    .key_valid   (key_valid),
    .start       (start),
    .stop_clear  (stop_clear),
    .door_closed (door_closed),
    .enc_enablen (enc_enablen),
    .time_bcd    (time_bcd),
    .magnetron_on(magnetron_on),
    .done        (done),
    .state       (state)
  );

  always #5 clk = ~clk;

  function automatic vec_t V(bit r, logic [3:0] kb, bit kv, bit st, bit sc, bit dc, int n,
                             logic [15:0] t, logic [2:0] s, bit m);
    vec_t v;
    v.r = r; v.kb = kb; v.kv = kv; v.st = st; v.sc = sc; v.dc = dc; v.n = n;
    v.t = t; v.s = s; v.m = m;
    return v;
  endfunction

  // Drive one record, hold it for n rising edges, then check #1 after the last edge.
  task automatic run(input string nm, input vec_t v);
    exp_t ex, got;
    rst = v.r; key_bcd = v.kb; key_valid = v.kv;
    start = v.st; stop_clear = v.sc; door_closed = v.dc;
    ex.t = v.t; ex.s = v.s; ex.m = v.m;
    ex.d = (v.s == S_DONE);
    ex.e = (v.s == S_COOK) || (v.s == S_PAUSE) || (v.s == S_DONE);
    sb.push_back(ex);
    repeat (v.n) @(posedge clk);
    #1;
    ex  = sb.pop_front();
    got = {time_bcd, state, magnetron_on, done, enc_enablen};
    n_vec++;
    if (got !== ex) begin
      n_bad++;
      $display("FAIL %s: got time=%h state=%0d mag=%b done=%b encn=%b, want time=%h state=%0d mag=%b done=%b encn=%b",
               nm, got.t, got.s, got.m, got.d, got.e, ex.t, ex.s, ex.m, ex.d, ex.e);
    end
  endtask

  task automatic digit(input logic [3:0] d, input logic [15:0] t, input logic [2:0] s);
    run("key_press", V(0, d, 1, 0, 0, 1, 4, t, s, 0));
    run("key_release", V(0, 4'd0, 0, 0, 0, 1, 4, t, s, 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want normal completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] m;
    // r  kb  kv st sc dc  n   time   state    mag
    tbl.push_back(V(1, 4'd0, 0, 0, 0, 1,   2, 16'h0000, S_IDLE,  0));
    tbl.push_back(V(0, 4'd1, 1, 0, 0, 1,   3, 16'h0000, S_IDLE,  0));
    tbl.push_back(V(0, 4'd1, 1, 0, 0, 1,   1, 16'h0001, S_SET,   0));
    tbl.push_back(V(0, 4'd1, 1, 0, 0, 1,  16, 16'h0001, S_SET,   0));
    tbl.push_back(V(0, 4'd0, 0, 0, 0, 1,   4, 16'h0001, S_SET,   0));
    tbl.push_back(V(0, 4'd3, 1, 0, 0, 1,   4, 16'h0013, S_SET,   0));
    tbl.push_back(V(0, 4'd0, 0, 0, 0, 1,   4, 16'h0013, S_SET,   0));
    tbl.push_back(V(0, 4'd0, 1, 0, 0, 1,   4, 16'h0130, S_SET,   0));
    tbl.push_back(V(0, 4'd0, 0, 0, 0, 1,   4, 16'h0130, S_SET,   0));
    tbl.push_back(V(0, 4'd0, 0, 0, 1, 1,   1, 16'h0000, S_IDLE,  0));
    tbl.push_back(V(0, 4'd0, 0, 0, 0, 1,   1, 16'h0000, S_IDLE,  0));
    tbl.push_back(V(0, 4'd2, 1, 0, 0, 1,   3, 16'h0000, S_IDLE,  0));
    tbl.push_back(V(0, 4'd0, 0, 0, 0, 1,   4, 16'h0000, S_IDLE,  0));
    tbl.push_back(V(0, 4'hA, 1, 0, 0, 1,   4, 16'h0000, S_IDLE,  0));
    tbl.push_back(V(0, 4'd0, 0, 0, 0, 1,   4, 16'h0000, S_IDLE,  0));
    tbl.push_back(V(0, 4'd5, 1, 0, 0, 1,   2, 16'h0000, S_IDLE,  0));
    tbl.push_back(V(0, 4'd6, 1, 0, 0, 1,   3, 16'h0000, S_IDLE,  0));
    tbl.push_back(V(0, 4'd6, 1, 0, 0, 1,   1, 16'h0006, S_SET,   0));
    tbl.push_back(V(0, 4'd0, 0, 0, 0, 1,   4, 16'h0006, S_SET,   0));
    tbl.push_back(V(0, 4'd0, 0, 0, 1, 1,   1, 16'h0000, S_IDLE,  0));
    tbl.push_back(V(0, 4'd0, 0, 0, 0, 1,   1, 16'h0000, S_IDLE,  0));
    tbl.push_back(V(0, 4'd1, 1, 0, 0, 1,   4, 16'h0001, S_SET,   0));
    tbl.push_back(V(0, 4'd0, 0, 0, 0, 1,   4, 16'h0001, S_SET,   0));
    tbl.push_back(V(0, 4'd2, 1, 0, 0, 1,   4, 16'h0012, S_SET,   0));
    tbl.push_back(V(0, 4'd0, 0, 0, 0, 1,   4, 16'h0012, S_SET,   0));
    tbl.push_back(V(0, 4'd0, 0, 1, 0, 1,   1, 16'h0012, S_COOK,  1));
    tbl.push_back(V(0, 4'd0, 0, 0, 0, 1,   9, 16'h0012, S_COOK,  1));
    tbl.push_back(V(0, 4'd0, 0, 0, 0, 1,   1, 16'h0011, S_COOK,  1));
    tbl.push_back(V(0, 4'd0, 0, 0, 0, 1, 109, 16'h0001, S_COOK,  1));
    tbl.push_back(V(0, 4'd0, 0, 0, 0, 1,   1, 16'h0000, S_DONE,  0));
    tbl.push_back(V(0, 4'd0, 0, 1, 0, 1,   1, 16'h0000, S_IDLE,  0));
    tbl.push_back(V(0, 4'd0, 0, 0, 0, 1,   1, 16'h0000, S_IDLE,  0));

    foreach (tbl[i]) run($sformatf("tbl%0d", i), tbl[i]);

    // Door interlock: 1:00 counts to 0:59, door open pauses, resume continues from 0:59.
    digit(4'd1, 16'h0001, S_SET);
    digit(4'd0, 16'h0010, S_SET);
    digit(4'd0, 16'h0100, S_SET);
    run("cook_start",     V(0, 0, 0, 1, 0, 1, 1, 16'h0100, S_COOK,  1));
    run("cook_hold",      V(0, 0, 0, 0, 0, 1, 9, 16'h0100, S_COOK,  1));
    run("sec_borrow",     V(0, 0, 0, 0, 0, 1, 1, 16'h0059, S_COOK,  1));
    run("door_open_comb", V(0, 0, 0, 0, 0, 0, 0, 16'h0059, S_COOK,  0));
    run("door_open_edge", V(0, 0, 0, 0, 0, 0, 1, 16'h0059, S_PAUSE, 0));
    run("door_closed",    V(0, 0, 0, 0, 0, 1, 3, 16'h0059, S_PAUSE, 0));
    run("resume",         V(0, 0, 0, 1, 0, 1, 1, 16'h0059, S_COOK,  1));
    run("resume_hold",    V(0, 0, 0, 0, 0, 1, 9, 16'h0059, S_COOK,  1));
    run("resume_tick",    V(0, 0, 0, 0, 0, 1, 1, 16'h0058, S_COOK,  1));
    run("stop_in_cook",   V(0, 0, 0, 0, 1, 1, 1, 16'h0058, S_PAUSE, 0));
    run("stop_low",       V(0, 0, 0, 0, 0, 1, 1, 16'h0058, S_PAUSE, 0));
    run("stop_in_pause",  V(0, 0, 0, 0, 1, 1, 1, 16'h0000, S_IDLE,  0));
    run("stop_low2",      V(0, 0, 0, 0, 0, 1, 1, 16'h0000, S_IDLE,  0));

    // Simultaneous start and stop edges in SET: stop wins.
    digit(4'd7, 16'h0007, S_SET);
    run("start_stop_same", V(0, 0, 0, 1, 1, 1, 1, 16'h0000, S_IDLE, 0));
    run("start_stop_low",  V(0, 0, 0, 0, 0, 1, 1, 16'h0000, S_IDLE, 0));

    // Five digits: the oldest falls off the top.
    m = 16'h0000;
    for (int i = 1; i <= 5; i++) begin
      m = {m[11:0], 4'(i)};
      digit(4'(i), m, S_SET);
    end
    run("five_digits", V(0, 0, 0, 0, 0, 1, 1, 16'h2345, S_SET, 0));
    run("clear_2345",  V(0, 0, 0, 0, 1, 1, 1, 16'h0000, S_IDLE, 0));
    run("clear_low",   V(0, 0, 0, 0, 0, 1, 1, 16'h0000, S_IDLE, 0));

    // Minutes borrow 10:00 -> 09:59, then reset mid-cook.
    digit(4'd1, 16'h0001, S_SET);
    digit(4'd0, 16'h0010, S_SET);
    digit(4'd0, 16'h0100, S_SET);
    digit(4'd0, 16'h1000, S_SET);
    run("start_1000",  V(0, 0, 0, 1, 0, 1, 1, 16'h1000, S_COOK, 1));
    run("hold_1000",   V(0, 0, 0, 0, 0, 1, 9, 16'h1000, S_COOK, 1));
    run("min_borrow",  V(0, 0, 0, 0, 0, 1, 1, 16'h0959, S_COOK, 1));
    run("rst_midcook", V(1, 0, 0, 0, 0, 1, 1, 16'h0000, S_IDLE, 0));
    run("rst_release", V(0, 0, 0, 0, 0, 1, 1, 16'h0000, S_IDLE, 0));

    // 0:90 counts down as 89; start with door open is ignored.
    digit(4'd9, 16'h0009, S_SET);
    digit(4'd0, 16'h0090, S_SET);
    run("start_door_open", V(0, 0, 0, 1, 0, 0, 1, 16'h0090, S_SET,  0));
    run("start_low",       V(0, 0, 0, 0, 0, 1, 1, 16'h0090, S_SET,  0));
    run("start_0090",      V(0, 0, 0, 1, 0, 1, 1, 16'h0090, S_COOK, 1));
    run("hold_0090",       V(0, 0, 0, 0, 0, 1, 9, 16'h0090, S_COOK, 1));
    run("over59_dec",      V(0, 0, 0, 0, 0, 1, 1, 16'h0089, S_COOK, 1));
    run("rst_cook2",       V(1, 0, 0, 0, 0, 1, 1, 16'h0000, S_IDLE, 0));
    run("idle_after_rst",  V(0, 0, 0, 0, 0, 1, 2, 16'h0000, S_IDLE, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
